// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: way index/mask typedefs, controller states and way helpers.
package lc3b_types;

  typedef logic [1:0] lc3b_way;
  typedef logic [3:0] lc3b_waymask;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } cache_state_t;

  // Lowest-numbered set bit wins when more than one way reports a hit.
  function automatic lc3b_way first_way(lc3b_waymask m);
    lc3b_way w;
    w = '0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) w = lc3b_way'(i);
    end
    return w;
  endfunction

  function automatic lc3b_waymask way_mask(lc3b_way w);
    return lc3b_waymask'(1) << w;
  endfunction

endpackage

// File: rtl/cache_control_4way_if.sv
// CPU port, array load strobes, LRU decoder link and physical memory port of the cache controller.
interface cache_control_4way_if;
  import lc3b_types::*;

  logic        mem_read;
  logic        mem_write;
  logic        mem_resp;
  lc3b_waymask hit;
  lc3b_waymask dirty_in;
  lc3b_waymask valid_in;
  lc3b_way     lru_way;
  logic        lru_load;
  lc3b_way     way_sel;
  lc3b_waymask data_load;
  lc3b_waymask tag_load;
  lc3b_waymask valid_load;
  lc3b_waymask dirty_load;
  logic        dirty_val;
  logic        datain_sel;
  logic        pmem_addr_sel;
  logic        pmem_read;
  logic        pmem_write;
  logic        pmem_resp;

  modport master (
    input  mem_read, mem_write, hit, dirty_in, valid_in, lru_way, pmem_resp,
    output mem_resp, lru_load, way_sel, data_load, tag_load, valid_load,
           dirty_load, dirty_val, datain_sel, pmem_addr_sel, pmem_read, pmem_write
  );

  modport slave (
    output mem_read, mem_write, hit, dirty_in, valid_in, lru_way, pmem_resp,
    input  mem_resp, lru_load, way_sel, data_load, tag_load, valid_load,
           dirty_load, dirty_val, datain_sel, pmem_addr_sel, pmem_read, pmem_write
  );

endinterface

// File: rtl/cache_control_4way_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_control_4way.sv
// 4-way cache control FSM: zero-wait hits, dirty-victim writeback, line allocation, perf counters.
//   state     | meaning
//   IDLE      | serve hits in the request cycle; on a miss latch the victim and count it
//   WRITEBACK | write the dirty victim line to pmem at {victim tag, index}
//   ALLOCATE  | read the requested line from pmem and load it into the victim way
module cache_control_4way
  import lc3b_types::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  cache_control_4way_if.master   bus,
  output logic [COUNT_WIDTH-1:0] hit_count,
  output logic [COUNT_WIDTH-1:0] miss_count
);

  cache_state_t state, next_state;
  lc3b_way      victim_q;
  lc3b_way      hit_way;
  logic         request;
  logic         victim_load;
  logic         hit_inc;
  logic         miss_inc;

  assign request = bus.mem_read | bus.mem_write;
  assign hit_way = first_way(bus.hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      victim_q <= '0;
    end else begin
      state <= next_state;
      if (victim_load) victim_q <= bus.lru_way;
    end
  end

  always_comb begin
    next_state        = state;
    victim_load       = 1'b0;
    hit_inc           = 1'b0;
    miss_inc          = 1'b0;
    bus.mem_resp      = 1'b0;
    bus.lru_load      = 1'b0;
    bus.way_sel       = '0;
    bus.data_load     = '0;
    bus.tag_load      = '0;
    bus.valid_load    = '0;
    bus.dirty_load    = '0;
    bus.dirty_val     = 1'b0;
    bus.datain_sel    = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    // Reset forces every strobe low, even if a hit is presented that cycle.
    if (!rst) begin
      case (state)
        IDLE: begin
          if (request && (|bus.hit)) begin
            bus.mem_resp = 1'b1;
            bus.lru_load = 1'b1;
            bus.way_sel  = hit_way;
            hit_inc      = 1'b1;
            if (bus.mem_write) begin
              bus.data_load  = way_mask(hit_way);
              bus.dirty_load = way_mask(hit_way);
              bus.dirty_val  = 1'b1;
            end
          end else if (request) begin
            victim_load = 1'b1;
            miss_inc    = 1'b1;
            if (bus.valid_in[bus.lru_way] && bus.dirty_in[bus.lru_way]) begin
              next_state = WRITEBACK;
            end else begin
              next_state = ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          bus.pmem_write    = 1'b1;
          bus.pmem_addr_sel = 1'b1;
          bus.way_sel       = victim_q;
          if (bus.pmem_resp) next_state = ALLOCATE;
        end
        ALLOCATE: begin
          bus.pmem_read = 1'b1;
          bus.way_sel   = victim_q;
          if (bus.pmem_resp) begin
            bus.data_load  = way_mask(victim_q);
            bus.tag_load   = way_mask(victim_q);
            bus.valid_load = way_mask(victim_q);
            bus.dirty_load = way_mask(victim_q);
            bus.datain_sel = 1'b1;
            next_state     = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_hit_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_miss_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_cache_control_4way.sv
// Random-traffic bench for cache_control_4way: a one-set cache/LRU model predicts events into a scoreboard.
module tb_cache_control_4way;
  import lc3b_types::*;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [CW-1:0] hit_count, miss_count;

  cache_control_4way_if cif();

  cache_control_4way #(.COUNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (cif.master),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  // kind: 0 = CPU completion, 1 = writeback done, 2 = fill
  typedef struct {
    int kind;
    int way;
    bit wr;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Environment model of the indexed set and of true-LRU order (front = least recently used).
  int tags[4];
  bit vld[4];
  bit drt[4];
  int lru_order[$];
  int m_hits = 0;
  int m_miss = 0;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int oh(int w);
    return 1 << w;
  endfunction

  function automatic int hitvec(int tag);
    int v = 0;
    for (int w = 0; w < 4; w++) if (vld[w] && tags[w] == tag) v |= oh(w);
    return v;
  endfunction

  function automatic int vecof(int sel);
    int v = 0;
    for (int w = 0; w < 4; w++) if (sel == 0 ? vld[w] : drt[w]) v |= oh(w);
    return v;
  endfunction

  task automatic touch(int w);
    for (int i = 0; i < lru_order.size(); i++) begin
      if (lru_order[i] == w) begin
        lru_order.delete(i);
        break;
      end
    end
    lru_order.push_back(w);
  endtask

  task automatic count_hit();
    if (m_hits < CMAX) m_hits++;
  endtask

  task automatic set_env(int tag);
    cif.hit      = lc3b_waymask'(hitvec(tag));
    cif.valid_in = lc3b_waymask'(vecof(0));
    cif.dirty_in = lc3b_waymask'(vecof(1));
    cif.lru_way  = lc3b_way'(lru_order[0]);
  endtask

  // Inputs the controller must ignore while a miss is in flight.
  task automatic garble();
    cif.hit      = lc3b_waymask'($urandom_range(0, 15));
    cif.valid_in = lc3b_waymask'($urandom_range(0, 15));
    cif.dirty_in = lc3b_waymask'($urandom_range(0, 15));
    cif.lru_way  = lc3b_way'($urandom_range(0, 3));
  endtask

  task automatic pmem_phase(bit drop);
    int d = $urandom_range(0, 4);
    if (drop) begin
      cif.mem_read  = 1'b0;
      cif.mem_write = 1'b0;
    end
    for (int i = 0; i < d; i++) begin
      garble();
      @(posedge clk); #1;
    end
    garble();
    cif.pmem_resp = 1'b1;
    @(posedge clk); #1;
    cif.pmem_resp = 1'b0;
  endtask

  task automatic idle_gap();
    int n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      cif.pmem_resp = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    cif.pmem_resp = 1'b0;
  endtask

  // Called at posedge+1 with the DUT in IDLE.
  task automatic do_req(bit wr, bit rd, int tag, bit drop);
    int hv, hw, v;
    ev_t e;
    hv = hitvec(tag);
    cif.mem_write = wr;
    cif.mem_read  = wr ? rd : 1'b1;
    set_env(tag);
    if (hv != 0) begin
      hw = 0;
      while (((hv >> hw) & 1) == 0) hw++;
      hv = hv | ((int'($urandom_range(0, 15)) << (hw + 1)) & 15);
      cif.hit = lc3b_waymask'(hv);
      e = '{kind: 0, way: hw, wr: wr};
      exp_q.push_back(e);
      count_hit();
      touch(hw);
      if (wr) drt[hw] = 1'b1;
      @(posedge clk); #1;
      cif.mem_read  = 1'b0;
      cif.mem_write = 1'b0;
    end else begin
      v = lru_order[0];
      if (m_miss < CMAX) m_miss++;
      if (vld[v] && drt[v]) begin
        e = '{kind: 1, way: v, wr: 1'b0};
        exp_q.push_back(e);
      end
      e = '{kind: 2, way: v, wr: 1'b0};
      exp_q.push_back(e);
      if (!drop) begin
        e = '{kind: 0, way: v, wr: wr};
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
      if (vld[v] && drt[v]) pmem_phase(1'b0);
      pmem_phase(drop);
      tags[v] = tag;
      vld[v]  = 1'b1;
      drt[v]  = 1'b0;
      set_env(tag);
      if (!drop) begin
        count_hit();
        touch(v);
        if (wr) drt[v] = 1'b1;
      end
      @(posedge clk); #1;
      cif.mem_read  = 1'b0;
      cif.mem_write = 1'b0;
      set_env(tag);
    end
    idle_gap();
    @(negedge clk);
    chk("pending_events", exp_q.size(), 0);
    chk("hit_count", int'(hit_count), m_hits);
    chk("miss_count", int'(miss_count), m_miss);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: pops one expected event whenever the DUT completes something.
  always @(negedge clk) begin : monitor
    ev_t e;
    int  kind;
    if (!rst) begin
      if (cif.mem_resp || (cif.pmem_resp && (cif.pmem_read || cif.pmem_write))) begin
        kind = cif.mem_resp ? 0 : (cif.pmem_write ? 1 : 2);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", kind + 10, -1);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", kind, e.kind);
          chk("way_sel", int'(cif.way_sel), e.way);
          if (e.kind == 0) begin
            chk("resp_lru_load", int'(cif.lru_load), 1);
            chk("resp_data_load", int'(cif.data_load), e.wr ? oh(e.way) : 0);
            chk("resp_dirty_load", int'(cif.dirty_load), e.wr ? oh(e.way) : 0);
            chk("resp_dirty_val", int'(cif.dirty_val), int'(e.wr));
            chk("resp_datain_sel", int'(cif.datain_sel), 0);
            chk("resp_tag_valid_load", int'({cif.tag_load, cif.valid_load}), 0);
          end else if (e.kind == 1) begin
            chk("wb_addr_sel", int'(cif.pmem_addr_sel), 1);
            chk("wb_loads", int'({cif.data_load, cif.tag_load, cif.lru_load}), 0);
          end else begin
            chk("fill_data_load", int'(cif.data_load), oh(e.way));
            chk("fill_tag_load", int'(cif.tag_load), oh(e.way));
            chk("fill_valid_load", int'(cif.valid_load), oh(e.way));
            chk("fill_dirty_load", int'(cif.dirty_load), oh(e.way));
            chk("fill_dirty_val", int'(cif.dirty_val), 0);
            chk("fill_datain_sel", int'(cif.datain_sel), 1);
            chk("fill_addr_sel", int'(cif.pmem_addr_sel), 0);
          end
        end
      end else begin
        chk("quiet_strobes", int'({cif.lru_load, cif.data_load, cif.tag_load,
                                   cif.valid_load, cif.dirty_load}), 0);
      end
    end
  end

  initial begin
    int tag;
    for (int w = 0; w < 4; w++) begin
      tags[w] = 0;
      vld[w]  = 1'b0;
      drt[w]  = 1'b0;
      lru_order.push_back(w);
    end
    rst           = 1'b1;
    cif.mem_read  = 1'b1;
    cif.mem_write = 1'b0;
    cif.hit       = 4'b0100;
    cif.dirty_in  = '0;
    cif.valid_in  = '0;
    cif.lru_way   = '0;
    cif.pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_resp", int'(cif.mem_resp), 0);
    chk("reset_strobes", int'({cif.lru_load, cif.data_load, cif.pmem_read, cif.pmem_write}), 0);
    chk("reset_hit_count", int'(hit_count), 0);
    chk("reset_miss_count", int'(miss_count), 0);
    @(posedge clk); #1;
    cif.mem_read = 1'b0;
    cif.hit      = '0;
    rst          = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 80; t++) begin
      do_req($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 5),
             $urandom_range(0, 9) == 0);
    end

    // Reset while a miss is in flight abandons the transfer.
    tag = 100;
    cif.mem_read = 1'b1;
    set_env(tag);
    @(posedge clk); #1;
    chk("miss_in_flight", int'(cif.pmem_read | cif.pmem_write), 1);
    rst          = 1'b1;
    cif.mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pmem_read", int'(cif.pmem_read), 0);
    chk("rst_pmem_write", int'(cif.pmem_write), 0);
    chk("rst_hit_count", int'(hit_count), 0);
    chk("rst_miss_count", int'(miss_count), 0);
    exp_q.delete();
    m_hits = 0;
    m_miss = 0;
    @(posedge clk); #1;

    tag = tags[lru_order[3]];
    for (int i = 0; i < 17; i++) do_req(1'b0, 1'b1, tag, 1'b0);
    @(negedge clk);
    chk("hit_count_saturated", int'(hit_count), CMAX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
